keypad_scanner: RTL and testbench

//  Scans a 4x4 matrix keypad for the vending-machine selection panel.
//  - Drives columns one at a time, active-low.
//  - Synchronises and debounces the row inputs.
//  - Emits one 4-bit key code per debounced press on a valid/ready interface.
//  - key_code feeds the 4-to-16 one-hot decoder directly downstream.

---
 rtl/kp_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 33 +++
 rtl/keypad_scanner.sv | 179 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kp_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Contents:
//   kp_state_t  scanner FSM states
//   NUM_ROWS, NUM_COLS, KEY_W  matrix geometry and key-code width
//   lowest_low  index of the lowest-numbered active-low row
package kp_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, REL_DB} kp_state_t;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned KEY_W    = 4;

  // Lowest row wins when several keys in the driven column are down.
  function automatic logic [1:0] lowest_low(input logic [NUM_ROWS-1:0] rows);
    lowest_low = 2'd0;
    for (int i = int'(NUM_ROWS) - 1; i >= 0; i--) begin
      if (!rows[i]) lowest_low = 2'(i);
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   d      in   WIDTH  asynchronous input
//   q      out  WIDTH  synchronised output (two clocks of latency)
// RESET_VAL sets the idle level both stages take in reset.
module sync_2ff #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and a one-entry valid/ready output.
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   row_i        in   4  keypad rows, active-low, asynchronous
//   col_o        out  4  column drive, active-low, exactly one bit low
//   key_code     out  4  {row_idx, col_idx} of the buffered key
//   key_valid    out  1  key_code holds an unconsumed key
//   key_ready    in   1  consumer accepts when key_valid & key_ready
//   key_overrun  out  1  one-cycle pulse when a key is dropped (buffer full)
module keypad_scanner
  import kp_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 16,
  parameter int unsigned DEBOUNCE_CNT = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row_i,
  output logic [NUM_COLS-1:0] col_o,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                key_overrun
);

  localparam int unsigned DWELL_W = $clog2(SCAN_DIV);
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CNT - 1);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
  localparam logic [DB_W-1:0]    DB_ONE     = DB_W'(1);

  logic [NUM_ROWS-1:0] row_s;

  kp_state_t          state_q, state_d;
  logic [1:0]         col_q, col_d;
  logic [1:0]         row_idx_q, row_idx_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DB_W-1:0]    db_q, db_d;
  logic               key_event;

  logic [KEY_W-1:0]   code_q, code_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;

  logic               row_sel;
  logic               rows_idle;

  // Rows idle high, so the synchroniser resets to all-ones to avoid a phantom press.
  sync_2ff #(
    .WIDTH     (NUM_ROWS),
    .RESET_VAL ({NUM_ROWS{1'b1}})
  ) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_i),
    .q     (row_s)
  );

  assign row_sel   = row_s[row_idx_q];
  assign rows_idle = &row_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SCAN;
      col_q     <= 2'd0;
      row_idx_q <= 2'd0;
      dwell_q   <= '0;
      db_q      <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_idx_q <= row_idx_d;
      dwell_q   <= dwell_d;
      db_q      <= db_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Scan / debounce FSM.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_idx_d = row_idx_q;
    dwell_d   = dwell_q;
    db_d      = db_q;
    key_event = 1'b0;

    unique case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (!rows_idle) begin
            row_idx_d = lowest_low(row_s);
            db_d      = '0;
            state_d   = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + DWELL_ONE;
        end
      end

      DEBOUNCE: begin
        if (row_sel) begin
          // Bounce: give up on this column and move on.
          db_d    = '0;
          dwell_d = '0;
          col_d   = col_q + 2'd1;
          state_d = SCAN;
        end else if (db_q == DB_LAST) begin
          key_event = 1'b1;
          db_d      = '0;
          state_d   = HELD;
        end else begin
          db_d = db_q + DB_ONE;
        end
      end

      HELD: begin
        if (rows_idle) begin
          db_d    = '0;
          state_d = REL_DB;
        end
      end

      REL_DB: begin
        if (!rows_idle) begin
          db_d    = '0;
          state_d = HELD;
        end else if (db_q == DB_LAST) begin
          db_d    = '0;
          dwell_d = '0;
          col_d   = col_q + 2'd1;
          state_d = SCAN;
        end else begin
          db_d = db_q + DB_ONE;
        end
      end

      default: state_d = SCAN;
    endcase
  end

  // One-entry output buffer; a new key may replace one being accepted this cycle.
  always_comb begin
    code_d    = code_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (key_event) begin
      if (!valid_q || key_ready) begin
        code_d  = {row_idx_q, col_q};
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && key_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    col_o        = '1;
    col_o[col_q] = 1'b0;
  end

  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_overrun = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=8).
// A physical keypad model turns a pressed-key mask and col_o into row_i;
// expected key codes come from the pressed mask (lowest row in the column).
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_ready = 1'b0;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_overrun;

  logic [15:0] pressed = '0;  // bit r*4+c = key at row r, column c is down

  int checks = 0;
  int errors = 0;

  logic [3:0] acc_q[$];
  int         ovr_cnt = 0;
  int         stab_err = 0;
  int         onehot_err = 0;
  logic       prev_valid = 1'b0;
  logic       prev_acc = 1'b0;
  logic [3:0] prev_code = '0;

  keypad_scanner #(
    .SCAN_DIV     (SD),
    .DEBOUNCE_CNT (DB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_i       (row_i),
    .col_o       (col_o),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_overrun (key_overrun)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a row is pulled low when a pressed key sits on the driven column.
  always_comb begin
    row_i = '1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
      end
    end
  end

  // Monitor: accepted keys, overrun pulses, code stability, column one-hot.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_acc   = 1'b0;
      end else begin
        if ($countones(~col_o) != 1) onehot_err++;
        if (prev_valid && !prev_acc && key_code != prev_code) stab_err++;
        if (key_valid && key_ready) acc_q.push_back(key_code);
        if (key_overrun) ovr_cnt++;
        prev_valid = key_valid;
        prev_acc   = key_valid && key_ready;
        prev_code  = key_code;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Returns just after the edge on which column c becomes driven.
  task automatic wait_col_start(input int c);
    logic [3:0] want;
    logic [3:0] prev;
    bit         found;
    want  = ~(4'b0001 << c);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      prev = col_o;
      tick();
      if (col_o == want && prev != want) found = 1'b1;
    end
    if (!found) check_eq("col_start_timeout", 0, 1);
  endtask

  task automatic press_release(input logic [15:0] mask, input int hold, input int gap);
    pressed = mask;
    ticks(hold);
    pressed = '0;
    ticks(gap);
  endtask

  // Expected code: lowest pressed row on the (single) pressed column.
  function automatic int ref_code(input logic [15:0] m);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (m[r*4+c]) return r * 4 + c;
      end
    end
    return -1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_col"}, int'(col_o), 4'hE);
    check_eq({tag, "_valid"}, int'(key_valid), 0);
    check_eq({tag, "_code"}, int'(key_code), 0);
    check_eq({tag, "_overrun"}, int'(key_overrun), 0);
  endtask

  initial begin
    int         base;
    int         ob;
    int         lat;
    int         col;
    logic [3:0] exp_col;
    logic [3:0] rmask;
    logic [15:0] mask;

    // 1. Reset values and column rotation.
    ticks(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      exp_col = ~(4'b0001 << ((k / SD) % 4));
      check_eq("col_rotation", int'(col_o), int'(exp_col));
      tick();
    end

    // 2. Single press row2/col1, exact latency, no auto-repeat.
    key_ready = 1'b1;
    base = acc_q.size();
    wait_col_start(1);
    pressed = 16'(1) << 9;
    lat = 0;
    while (!key_valid && lat < 100) begin
      tick();
      lat++;
    end
    check_eq("press_latency", lat, SD + DB);
    ticks(60 - lat);
    pressed = '0;
    ticks(30);
    check_eq("press_count", acc_q.size() - base, 1);
    if (acc_q.size() > base) check_eq("press_code", int'(acc_q[base]), 9);

    // 3. Bounce on row0 during col0 dwell.
    base = acc_q.size();
    wait_col_start(0);
    pressed = 16'(1);
    ticks(3);
    pressed = '0;
    tick();
    check_eq("bounce_freeze0", int'(col_o), 4'hE);
    tick();
    check_eq("bounce_freeze1", int'(col_o), 4'hE);
    tick();
    check_eq("bounce_resume", int'(col_o), 4'hD);
    ticks(SD - 1);
    check_eq("bounce_dwell", int'(col_o), 4'hD);
    tick();
    check_eq("bounce_next_col", int'(col_o), 4'hB);
    ticks(20);
    check_eq("bounce_no_key", acc_q.size() - base, 0);

    // 4. Overrun with consumer stalled.
    key_ready = 1'b0;
    base = acc_q.size();
    ob = ovr_cnt;
    press_release(16'(1) << 5, 60, 30);
    check_eq("stall_valid", int'(key_valid), 1);
    check_eq("stall_code", int'(key_code), 5);
    press_release(16'(1) << 10, 60, 30);
    check_eq("ovr_valid", int'(key_valid), 1);
    check_eq("ovr_code", int'(key_code), 5);
    check_eq("ovr_pulses", ovr_cnt - ob, 1);
    check_eq("ovr_no_accept", acc_q.size() - base, 0);
    key_ready = 1'b1;
    tick();
    check_eq("accept_clears_valid", int'(key_valid), 0);
    check_eq("accept_code_holds", int'(key_code), 5);
    check_eq("accept_count", acc_q.size() - base, 1);
    if (acc_q.size() > base) check_eq("accept_code", int'(acc_q[base]), 5);

    // 5. Rows 1 and 3 on column 2 together.
    base = acc_q.size();
    mask = (16'(1) << 6) | (16'(1) << 14);
    press_release(mask, 60, 30);
    check_eq("multi_count", acc_q.size() - base, 1);
    if (acc_q.size() > base) check_eq("multi_code", int'(acc_q[base]), ref_code(mask));

    // 6a. Reset during DEBOUNCE.
    wait_col_start(3);
    pressed = 16'(1) << 3;
    ticks(6);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_debounce");
    pressed = '0;
    ticks(3);
    rst_n = 1'b1;
    base = acc_q.size();
    ticks(40);
    check_eq("rst_debounce_no_key", acc_q.size() - base, 0);
    check_eq("rst_debounce_valid", int'(key_valid), 0);

    // 6b. Reset with a key pending.
    key_ready = 1'b0;
    press_release(16'(1) << 7, 60, 30);
    check_eq("pending_valid", int'(key_valid), 1);
    check_eq("pending_code", int'(key_code), 7);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_pending");
    ticks(2);
    rst_n = 1'b1;
    key_ready = 1'b1;
    base = acc_q.size();
    ticks(30);
    check_eq("rst_pending_valid", int'(key_valid), 0);
    check_eq("rst_pending_no_key", acc_q.size() - base, 0);

    // Random single- and multi-row presses within one column.
    for (int n = 0; n < 12; n++) begin
      col   = $urandom_range(0, 3);
      rmask = 4'($urandom_range(1, 15));
      mask  = '0;
      for (int r = 0; r < 4; r++) begin
        if (rmask[r]) mask[r*4+col] = 1'b1;
      end
      base = acc_q.size();
      press_release(mask, $urandom_range(40, 80), $urandom_range(20, 40));
      check_eq("rnd_count", acc_q.size() - base, 1);
      if (acc_q.size() > base) check_eq("rnd_code", int'(acc_q[base]), ref_code(mask));
    end

    check_eq("code_stability", stab_err, 0);
    check_eq("col_onehot", onehot_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
